// File: rtl/uart_tx.sv
// UART transmitter, 8N1, with a small transmit FIFO in front of the serialiser.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per serial bit
//   FIFO_DEPTH   - transmit FIFO entries (power of two, >= 2)
//
// Ports:
//   clk_i     - clock, rising edge
//   rst_i     - asynchronous active-high reset
//   data_i    - byte to transmit
//   valid_i   - data_i is valid; accepted when ready_o is also high
//   ready_o   - FIFO has room (decoded from registered count only)
//   uart_tx_o - serial line, idle high, driven straight from a flop
//   busy_o    - a frame is in progress or bytes are still queued
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       uart_tx_o,
  output logic       busy_o
);

  localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BitCntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BitCntW-1:0] BitLast   = BitCntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]    CountFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e              state_q, state_d;
  logic [7:0]          fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q, count_d;
  logic [BitCntW-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                push, pop, fifo_empty, bit_end;

  assign fifo_empty = (count_q == '0);
  assign ready_o    = (count_q < CountFull);
  assign push       = valid_i & ready_o;
  assign busy_o     = (state_q != StIdle) | ~fifo_empty;
  assign uart_tx_o  = tx_q;
  assign bit_end    = (clk_cnt_q == BitLast);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_mem_q[rd_ptr_q];
          clk_cnt_d = '0;
          bit_idx_d = '0;
          tx_d      = 1'b0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          tx_d      = shift_q[0];
          state_d   = StData;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            // Shift right so the next bit to send is always at shift_q[0].
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (!fifo_empty) begin
            // Chain straight into the next start bit with no idle gap.
            pop       = 1'b1;
            shift_d   = fifo_mem_q[rd_ptr_q];
            bit_idx_d = '0;
            tx_d      = 1'b0;
            state_d   = StStart;
          end else begin
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      // Pointer width equals log2(depth), so increment wraps naturally.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Data storage needs no reset.
  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
    if (push) fifo_mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (8 clk/bit depth 4, 4 clk/bit depth 2), a serial-line
// decoder per instance feeding receive queues, and an expected-byte scoreboard.
module tb_uart_tx;

  localparam int CPB0 = 8;
  localparam int CPB1 = 4;

  logic       clk;
  logic       rst0, rst1;
  logic [7:0] data0, data1;
  logic       valid0, valid1;
  logic       ready0, ready1;
  logic       tx0, tx1;
  logic       busy0, busy1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp0_q[$], exp1_q[$];
  logic [7:0] rx0_q[$], rx1_q[$];
  int         rx0_st_q[$], rx1_st_q[$];
  bit         rx0_ok_q[$], rx1_ok_q[$];

  uart_tx #(.CLKS_PER_BIT(CPB0), .FIFO_DEPTH(4)) u_dut0 (
    .clk_i    (clk),
    .rst_i    (rst0),
    .data_i   (data0),
    .valid_i  (valid0),
    .ready_o  (ready0),
    .uart_tx_o(tx0),
    .busy_o   (busy0)
  );

  uart_tx #(.CLKS_PER_BIT(CPB1), .FIFO_DEPTH(2)) u_dut1 (
    .clk_i    (clk),
    .rst_i    (rst1),
    .data_i   (data1),
    .valid_i  (valid1),
    .ready_o  (ready1),
    .uart_tx_o(tx1),
    .busy_o   (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Serial decoder: samples each negedge, requires every bit constant for cpb samples.
  task automatic mon(input int id, input int cpb);
    bit         in_frame;
    bit         ok;
    int         smp;
    int         st;
    logic [7:0] b;
    logic       cur, line, r;
    in_frame = 1'b0;
    ok = 1'b1;
    smp = 0;
    st = 0;
    b = '0;
    cur = 1'b1;
    forever begin
      @(negedge clk);
      line = (id == 0) ? tx0 : tx1;
      r    = (id == 0) ? rst0 : rst1;
      if (r) begin
        in_frame = 1'b0;
      end else if (!in_frame && line === 1'b0) begin
        in_frame = 1'b1;
        smp = 0;
        st = cyc;
        ok = 1'b1;
        b = '0;
      end
      if (in_frame) begin
        if (smp % cpb == 0) cur = line;
        else if (line !== cur) ok = 1'b0;
        if (smp % cpb == cpb - 1) begin
          if (smp / cpb == 0) begin
            if (cur !== 1'b0) ok = 1'b0;
          end else if (smp / cpb <= 8) begin
            b[3'(smp / cpb - 1)] = cur;
          end else if (cur !== 1'b1) begin
            ok = 1'b0;
          end
        end
        smp++;
        if (smp == 10 * cpb) begin
          in_frame = 1'b0;
          if (id == 0) begin
            rx0_q.push_back(b); rx0_st_q.push_back(st); rx0_ok_q.push_back(ok);
          end else begin
            rx1_q.push_back(b); rx1_st_q.push_back(st); rx1_ok_q.push_back(ok);
          end
        end
      end
    end
  endtask

  initial fork
    mon(0, CPB0);
    mon(1, CPB1);
  join

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_rx(input int id, input int n, input int limit, input string tag);
    int t = 0;
    while (((id == 0) ? rx0_q.size() : rx1_q.size()) < n && t < limit) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_frames"}, ((id == 0) ? rx0_q.size() : rx1_q.size()) >= n, 1);
  endtask

  task automatic pop_frame(input int id, input string tag, input int exp_st);
    logic [7:0] eb, rb;
    int         st;
    bit         ok;
    if ((id == 0 && (exp0_q.size() == 0 || rx0_q.size() == 0)) ||
        (id == 1 && (exp1_q.size() == 0 || rx1_q.size() == 0))) begin
      checks++;
      errors++;
      $error("FAIL %s_avail got no frame exp frame", tag);
      return;
    end
    if (id == 0) begin
      eb = exp0_q.pop_front(); rb = rx0_q.pop_front();
      st = rx0_st_q.pop_front(); ok = rx0_ok_q.pop_front();
    end else begin
      eb = exp1_q.pop_front(); rb = rx1_q.pop_front();
      st = rx1_st_q.pop_front(); ok = rx1_ok_q.pop_front();
    end
    check({tag, "_byte"}, 32'(rb), 32'(eb));
    check({tag, "_shape"}, 32'(ok), 32'd1);
    check({tag, "_start"}, 32'(st), 32'(exp_st));
  endtask

  initial begin
    int n, a, b, t;
    int acc[6];
    bit low_seen, busy_seen;
    rst0 = 1'b1; rst1 = 1'b1;
    valid0 = 1'b0; valid1 = 1'b0;
    data0 = '0; data1 = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx0), 32'd1);
    check("rst_ready", 32'(ready0), 32'd1);
    check("rst_busy", 32'(busy0), 32'd0);
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (2) @(negedge clk);

    // Single 0x55 frame: latency, bit timing, busy fall.
    valid0 = 1'b1; data0 = 8'h55; exp0_q.push_back(8'h55);
    @(negedge clk);
    n = cyc; valid0 = 1'b0;
    check("lat_tx_high", 32'(tx0), 32'd1);
    check("busy_queued", 32'(busy0), 32'd1);
    @(negedge clk);
    check("lat_tx_low", 32'(tx0), 32'd0);
    wait_rx(0, 1, 20 * CPB0, "f55");
    pop_frame(0, "f55", n + 1);
    wait_until(n + 10 * CPB0);
    check("busy_last_stop", 32'(busy0), 32'd1);
    wait_until(n + 10 * CPB0 + 1);
    check("busy_done", 32'(busy0), 32'd0);
    check("idle_tx", 32'(tx0), 32'd1);
    repeat (3) @(negedge clk);

    // Held valid with 0x00..0x05: FIFO fills, then back-to-back frames.
    for (int k = 0; k < 6; k++) begin
      data0 = 8'(k); valid0 = 1'b1;
      t = 0;
      while (!ready0 && t < 40 * CPB0) begin
        @(negedge clk);
        t++;
      end
      @(negedge clk);
      acc[k] = cyc;
      exp0_q.push_back(8'(k));
      if (k == 4) check("full_ready", 32'(ready0), 32'd0);
    end
    valid0 = 1'b0;
    for (int k = 1; k < 5; k++) check("acc_consec", 32'(acc[k] - acc[0]), 32'(k));
    check("acc_after_stop", 32'(acc[5] - acc[0]), 32'(10 * CPB0 + 2));
    wait_rx(0, 6, 80 * CPB0, "burst");
    for (int k = 0; k < 6; k++) pop_frame(0, "burst", acc[0] + 1 + k * 10 * CPB0);
    wait_until(acc[0] + 60 * CPB0 + 1);
    check("burst_busy_done", 32'(busy0), 32'd0);
    repeat (3) @(negedge clk);

    // Reset during DATA bit 3 of 0xA5 with 0x3C queued.
    valid0 = 1'b1; data0 = 8'hA5;
    @(negedge clk);
    a = cyc; data0 = 8'h3C;
    @(negedge clk);
    valid0 = 1'b0;
    wait_until(a + 4 * CPB0 + 3);
    check("bit3_value", 32'(tx0), 32'd0);
    #2;
    rst0 = 1'b1;
    #1;
    check("async_tx", 32'(tx0), 32'd1);
    check("async_ready", 32'(ready0), 32'd1);
    check("async_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    #1;
    rst0 = 1'b0;
    low_seen = 1'b0; busy_seen = 1'b0;
    repeat (20000) begin
      @(negedge clk);
      if (tx0 !== 1'b1) low_seen = 1'b1;
      if (busy0 !== 1'b0) busy_seen = 1'b1;
    end
    check("post_rst_line", 32'(low_seen), 32'd0);
    check("post_rst_busy", 32'(busy_seen), 32'd0);
    check("post_rst_rx", 32'(rx0_q.size()), 32'd0);

    // Loopback pair 0xA5, 0x5A.
    valid0 = 1'b1; data0 = 8'hA5; exp0_q.push_back(8'hA5);
    @(negedge clk);
    a = cyc; data0 = 8'h5A; exp0_q.push_back(8'h5A);
    @(negedge clk);
    valid0 = 1'b0;
    wait_rx(0, 2, 30 * CPB0, "loop");
    pop_frame(0, "loop", a + 1);
    pop_frame(0, "loop", a + 1 + 10 * CPB0);

    // Small instance: 0xFF, 0x00, 0x81; full at 2 entries; blocked push ignored.
    valid1 = 1'b1; data1 = 8'hFF; exp1_q.push_back(8'hFF);
    @(negedge clk);
    b = cyc; data1 = 8'h00; exp1_q.push_back(8'h00);
    check("s_ready_one", 32'(ready1), 32'd1);
    @(negedge clk);
    data1 = 8'h81; exp1_q.push_back(8'h81);
    @(negedge clk);
    check("s_ready_full", 32'(ready1), 32'd0);
    data1 = 8'h77;
    repeat (10) @(negedge clk);
    valid1 = 1'b0;
    wait_rx(1, 3, 40 * CPB1, "small");
    for (int k = 0; k < 3; k++) pop_frame(1, "small", b + 1 + k * 10 * CPB1);
    wait_until(b + 30 * CPB1);
    check("s_busy_last", 32'(busy1), 32'd1);
    wait_until(b + 30 * CPB1 + 1);
    check("s_busy_done", 32'(busy1), 32'd0);
    repeat (20 * CPB1) @(negedge clk);
    check("s_no_extra", 32'(rx1_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
